// File: rtl/outfifo.sv
// Output buffer between a processing core and its consumer: a DEPTH-entry FIFO.
// All outputs, including cstop, decode registered state only, so stop paths never chain.
module outfifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AFULL = DEPTH - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic [W-1:0]             cdata_i,
   input  logic                     cvalid_i,
   output logic                     cstop_o,
   output logic [W-1:0]             odata_o,
   output logic                     ovalid_o,
   input  logic                     ostop_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     afull_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
   localparam logic [CntW-1:0] CntAfull = CntW'(AFULL);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop, mem_we;

   assign cstop_o  = (count_q == CntFull);
   assign ovalid_o = (count_q != '0);
   assign afull_o  = (count_q >= CntAfull);
   assign count_o  = count_q;
   assign odata_o  = ovalid_o ? mem_q[rd_ptr_q] : '0;

   assign push   = cvalid_i && !cstop_o;
   assign pop    = ovalid_o && !ostop_i;
   // A push in a flush or reset cycle is discarded, so keep it out of memory too.
   assign mem_we = push && !flush_i && !reset;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         if (push && !pop) begin
            count_d = count_q + CntOne;
         end else if (pop && !push) begin
            count_d = count_q - CntOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= cdata_i;
      end
   end

endmodule

// File: doc/outfifo.md
# outfifo

Parametrised output buffer between a processing core and the downstream consumer. It generalises the single-entry output register to a DEPTH-entry FIFO with configurable data width, occupancy reporting, an almost-full flag and a synchronous flush. `cstop` is driven only from registered state, so there is no combinational path from `ostop` to `cstop`; this breaks the stop-path timing chain across chained stages.

## Interface
- `W`, 32: data width in bits; data is treated as signed and passed through unmodified.
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `AFULL`, DEPTH-1: occupancy threshold for `afull`; legal range 1..DEPTH.
- `clk`  in  1  clock, all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clock clk.
- `flush`  in  1  synchronous discard of all buffered entries.
- `cdata`  in  W  signed data from core.
- `cvalid`  in  1  `cdata` valid this cycle.
- `cstop`  out  1  backpressure to core; high means input not accepted.
- `odata`  out  W  signed head-of-FIFO data.
- `ovalid`  out  1  `odata` valid.
- `ostop`  in  1  downstream backpressure.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `afull`  out  1  high when count ≥ AFULL.

## Operation
- Push: occurs when `cvalid && !cstop`; writes `cdata` at the write pointer, which then advances.
- Pop: occurs when `ovalid && !ostop`; the read pointer advances.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is held in `count`, never derived from the pointers alone.
- `cstop` = (count == DEPTH). It does not depend on `ostop` or `cvalid` in the same cycle.
- `ovalid` = (count != 0). `odata` = mem[rd_ptr] when `ovalid`, else 0.
- `afull` = (count ≥ AFULL), decoded from the registered count.
- Count update:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged
- Simultaneous push and pop at count==DEPTH: cannot occur, because `cstop` blocks the push. The pop proceeds and `cstop` deasserts next cycle.
- Simultaneous push and pop at 0<count<DEPTH: both succeed; order is preserved.
- Push at count==0: the data is not forwarded in the same cycle. `ovalid` rises on the next cycle.
- `flush`: next cycle, count=0 and pointers=0. Any push or pop in the flush cycle is discarded.
- `reset` has priority over `flush`. Reset mid-operation discards all contents with no partial outputs.
- Memory contents are not reset; only pointers and count are.
- Data is stored and presented bit-exact; no sign extension or truncation.

## Timing
- Reset values: count=0, `ovalid`=0, `odata`=0, `cstop`=0, `afull`=0 (or 1 if AFULL==0, which is illegal), pointers=0.
- Latency: push in cycle N appears on `odata` with `ovalid`=1 in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- Full-to-not-full: pop at count==DEPTH in cycle N gives `cstop`=0 in cycle N+1.
- `ostop` held high: `odata`/`ovalid` stay stable until the pop. The head never changes under backpressure.
- All outputs are glitch-free functions of registered state.

## Test plan
- Reset, then idle: count=0, `ovalid`=0, `odata`=0, `cstop`=0, `afull`=0 for 5 cycles.
- DEPTH=4, `ostop`=1, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
  - 4 accepted; `afull` rises when count=3; `cstop`=1 from the cycle after the 4th push.
  - 0x55 is held by the core.
  - `odata`=0x11 stable throughout.
- From full, drop `ostop`, keep `cvalid` with 0x55:
  - outputs read 0x11,0x22,0x33,0x44,0x55 in order.
  - `cstop` drops one cycle after the first pop.
  - count returns to 0 with no duplicates or losses.
- Continuous push and pop of 0..63 with `ostop`=0: 1-cycle latency, count stays at 1, pointers wrap ≥15 times, sequence intact.
- Random `cvalid`/`ostop` (50%) over 2000 cycles with negative values (e.g. −1, −2^(W−1)): scoreboard matches bit-exact, and count always equals pushes − pops in 0..DEPTH.
- Flush at count=3 with a simultaneous push and pop: next cycle count=0 and `ovalid`=0. Reset asserted with flush: same result, and the first subsequent push reads out correctly.
